// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and pointer helper for the pipeline-stage FIFO.
package pipe_pkg;
   localparam int   BUNDLE_W   = 41;
   localparam logic RST_ACTIVE = 1'b0;
   function automatic int next_ptr(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction
endpackage

// File: rtl/pipe_fifo_ptr.sv
// pipe_fifo_ptr: modulo-DEPTH pointer register with sync reset, flush and advance.
module pipe_fifo_ptr
   import pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          adv,
   output logic [PW-1:0] ptr
);
   logic [PW-1:0] ptr_q, ptr_d;
   always_comb ptr_d = (rst == RST_ACTIVE || flush) ? '0 :
                       adv ? PW'(next_ptr(int'(ptr_q), DEPTH)) : ptr_q;
   always_ff @(posedge clk) ptr_q <= ptr_d;
   assign ptr = ptr_q;
endmodule

// File: rtl/pipe_fifo.sv
// pipe_fifo: first-word-fall-through FIFO between pipeline stages; empty slot reads as zero.
module pipe_fifo
   import pipe_pkg::*;
#(
   parameter int WIDTH    = BUNDLE_W,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1,
   localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count,
   output logic             almost_full
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop;

   assign in_ready    = count_q != CW'(DEPTH);
   assign out_valid   = count_q != '0;
   assign out_data    = out_valid ? mem_q[rd_ptr] : '0;
   assign count       = count_q;
   assign almost_full = count_q >= CW'(AF_LEVEL);
   assign push        = in_valid & in_ready;
   assign pop         = out_valid & out_ready;

   pipe_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr (
      .clk(clk), .rst(rst), .flush(flush), .adv(push), .ptr(wr_ptr));
   pipe_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd (
      .clk(clk), .rst(rst), .flush(flush), .adv(pop), .ptr(rd_ptr));

   always_comb count_d = flush ? '0 :
                         (push && !pop) ? count_q + CW'(1) :
                         (pop && !push) ? count_q - CW'(1) : count_q;

   // Storage is only cleared by reset; after a flush stale data is hidden by the zero mux.
   always_ff @(posedge clk) begin
      if (rst == RST_ACTIVE) begin
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         count_q <= count_d;
         if (push && !flush) mem_q[wr_ptr] <= in_data;
      end
   end
endmodule

// File: tb/tb_pipe_fifo.sv
// tb_pipe_fifo: directed vectors for pipe_fifo at DEPTH=4 and DEPTH=3.
module tb_pipe_fifo;
   logic        clk = 1'b0;
   logic        rst, flush;
   logic        iv, ordy, ir, ov, af;
   logic [40:0] din, dout;
   logic [2:0]  cnt;
   logic        iv3, ordy3, ir3, ov3, af3;
   logic [40:0] din3, dout3;
   logic [1:0]  cnt3;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pipe_fifo #(.WIDTH(41), .DEPTH(4), .AF_LEVEL(3)) u4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(iv), .in_data(din),
      .in_ready(ir), .out_valid(ov), .out_data(dout), .out_ready(ordy),
      .count(cnt), .almost_full(af));

   pipe_fifo #(.WIDTH(41), .DEPTH(3), .AF_LEVEL(2)) u3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(iv3), .in_data(din3),
      .in_ready(ir3), .out_valid(ov3), .out_data(dout3), .out_ready(ordy3),
      .count(cnt3), .almost_full(af3));

   typedef struct {
      logic        rst, flush, iv;
      logic [40:0] d;
      logic        ordy, e_ir, e_ov;
      logic [40:0] e_od;
      logic [2:0]  e_cnt;
      logic        e_af;
   } vec_t;

   vec_t tv [23];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // rst flush iv data ordy | in_ready out_valid out_data count af  (outputs after the edge)
      tv[0]  = '{0,0,1,41'h1_2345_6789,0, 1,0,41'h0, 3'd0,0};
      tv[1]  = '{1,0,1,41'h1,0, 1,1,41'h1, 3'd1,0};
      tv[2]  = '{1,0,1,41'h2,0, 1,1,41'h1, 3'd2,0};
      tv[3]  = '{1,0,1,41'h3,0, 1,1,41'h1, 3'd3,1};
      tv[4]  = '{1,0,1,41'h4,0, 0,1,41'h1, 3'd4,1};
      tv[5]  = '{1,0,1,41'h5,0, 0,1,41'h1, 3'd4,1};
      tv[6]  = '{1,0,0,41'h0,1, 1,1,41'h2, 3'd3,1};
      tv[7]  = '{1,0,0,41'h0,1, 1,1,41'h3, 3'd2,0};
      tv[8]  = '{1,0,0,41'h0,1, 1,1,41'h4, 3'd1,0};
      tv[9]  = '{1,0,0,41'h0,1, 1,0,41'h0, 3'd0,0};
      tv[10] = '{1,0,1,41'h10,1, 1,1,41'h10, 3'd1,0};
      tv[11] = '{1,0,1,41'h11,0, 1,1,41'h10, 3'd2,0};
      tv[12] = '{1,0,1,41'h12,0, 1,1,41'h10, 3'd3,1};
      tv[13] = '{1,0,1,41'h13,0, 0,1,41'h10, 3'd4,1};
      tv[14] = '{1,0,1,41'h14,1, 1,1,41'h11, 3'd3,1};
      tv[15] = '{1,0,1,41'h14,0, 0,1,41'h11, 3'd4,1};
      tv[16] = '{1,0,0,41'h0,1, 1,1,41'h12, 3'd3,1};
      tv[17] = '{1,1,1,41'h99,1, 1,0,41'h0, 3'd0,0};
      tv[18] = '{1,0,1,41'hA,0, 1,1,41'hA, 3'd1,0};
      tv[19] = '{1,0,0,41'h0,1, 1,0,41'h0, 3'd0,0};
      tv[20] = '{1,0,1,41'h55,0, 1,1,41'h55, 3'd1,0};
      tv[21] = '{0,0,1,41'h66,1, 1,0,41'h0, 3'd0,0};
      tv[22] = '{1,0,0,41'h0,0, 1,0,41'h0, 3'd0,0};
      iv3 = 0; din3 = '0; ordy3 = 0;
      for (int i = 0; i < 23; i++) begin
         rst = tv[i].rst; flush = tv[i].flush; iv = tv[i].iv; din = tv[i].d; ordy = tv[i].ordy;
         cyc();
         chk($sformatf("v%0d in_ready", i), 64'(ir), 64'(tv[i].e_ir));
         chk($sformatf("v%0d out_valid", i), 64'(ov), 64'(tv[i].e_ov));
         chk($sformatf("v%0d out_data", i), 64'(dout), 64'(tv[i].e_od));
         chk($sformatf("v%0d count", i), 64'(cnt), 64'(tv[i].e_cnt));
         chk($sformatf("v%0d almost_full", i), 64'(af), 64'(tv[i].e_af));
      end
      // Streaming at count=2 across several pointer wraps
      rst = 1; flush = 0; ordy = 0; iv = 1;
      din = 41'd100; cyc();
      din = 41'd101; cyc();
      chk("stream prefill count", 64'(cnt), 64'd2);
      ordy = 1;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("stream out_data %0d", i), 64'(dout), 64'(100 + i));
         din = 41'(102 + i);
         cyc();
         chk($sformatf("stream count %0d", i), 64'(cnt), 64'd2);
      end
      iv = 0; cyc(); cyc();
      chk("stream drained", 64'(ov), 64'd0);
      // DEPTH=3, AF_LEVEL=2: wrap 2->0 and almost_full at 2
      ordy3 = 0; iv3 = 1;
      din3 = 41'd200; cyc();
      chk("d3 af at 1", 64'(af3), 64'd0);
      din3 = 41'd201; cyc();
      chk("d3 af at 2", 64'(af3), 64'd1);
      chk("d3 count 2", 64'(cnt3), 64'd2);
      ordy3 = 1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("d3 out_data %0d", i), 64'(dout3), 64'(200 + i));
         iv3 = (i < 8);
         din3 = 41'(202 + i);
         cyc();
      end
      chk("d3 empty count", 64'(cnt3), 64'd0);
      chk("d3 empty data", 64'(dout3), 64'd0);
      ordy3 = 0; iv3 = 1;
      for (int i = 0; i < 3; i++) begin
         din3 = 41'(300 + i);
         cyc();
      end
      chk("d3 full in_ready", 64'(ir3), 64'd0);
      chk("d3 full count", 64'(cnt3), 64'd3);
      chk("d3 full head", 64'(dout3), 64'd300);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipe_fifo.md
# pipe_fifo

Parametrised first-word-fall-through FIFO that buffers instruction/control bundles between pipeline stages of the IITB-RISC core. It replaces the single-entry enable-gated stage register with a DEPTH-entry circular buffer, a valid/ready handshake on both sides, a synchronous flush for branch/jump squashes, and occupancy/almost-full status for upstream stall logic. Empty-slot output is forced to all-zeros so downstream stages see a clean bubble.

## Interface
- WIDTH, 41, bit width of one stored bundle.
- DEPTH, 4, number of entries; any integer >= 2, not restricted to powers of two.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- flush  input  1  synchronous squash of all stored entries.
- in_valid  input  1  upstream presents in_data.
- in_data  input  WIDTH  bundle to enqueue.
- in_ready  output  1  FIFO can accept this cycle.
- out_valid  output  1  out_data holds the oldest entry.
- out_data  output  WIDTH  oldest entry; all-zeros when out_valid=0.
- out_ready  input  1  downstream consumes this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy.
- almost_full  output  1  count >= AF_LEVEL.

## Operation
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr, read pointer rd_ptr, occupancy counter count.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); combinational from registered count only, never from out_ready (no pass-through when full).
- out_valid = (count != 0); out_data = mem[rd_ptr] when out_valid, else WIDTH'd0.
- push: mem[wr_ptr] <= in_data; wr_ptr advances. pop: rd_ptr advances.
- Pointer advance: ptr == DEPTH-1 -> 0, else ptr+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Priority per edge: rst=0 > flush=1 > push/pop.
- rst=0: wr_ptr, rd_ptr, count <= 0; storage array also cleared to zeros.
- flush=1 (rst=1): wr_ptr, rd_ptr, count <= 0; push and pop in that cycle are discarded; storage contents need not be cleared (masked by out_valid).
- Writes to a full FIFO and reads from an empty one are impossible by construction; no overflow/underflow state.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0 (AF_LEVEL >= 1).
- Latency: entry pushed at edge N is visible on out_data/out_valid after edge N (one cycle, no same-cycle bypass when empty).
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- Empty + push + out_ready: push accepted, no pop (out_valid=0); count becomes 1.
- Full + pop + in_valid: pop accepted, push refused (in_ready=0); count becomes DEPTH-1; in_ready rises next cycle.
- Flush takes effect at the edge it is sampled; outputs show empty state the following cycle.
- Reset asserted mid-stream: all state zeroed at that edge regardless of handshakes.
- All outputs derive from registers plus the empty-zero mux; no combinational path from in_* to out_* or from out_ready to in_ready.

## Structure
- Shared package pipe_pkg: default bundle width constant (41), reset polarity constant, pointer-increment function next_ptr(ptr, depth).
- One sub-module, pipe_fifo_ptr: modulo-DEPTH pointer register with rst, flush, advance inputs; instantiated twice (write and read).
- Top holds storage array, count register, handshake logic, and output zero mux.

## Test plan
- Reset: hold rst=0 with in_valid=1, in_data=41'h1_2345_6789 -> in_ready=1, out_valid=0, out_data=0, count=0 after release.
- Fill/drain, DEPTH=4: push 1,2,3,4 with out_ready=0 -> count=4, in_ready=0, almost_full=1; 5th push refused; drain -> outputs 1,2,3,4 in order, then out_data=0.
- Streaming: count=2, push and pop every cycle for 20 cycles with incrementing data -> count stays 2, ordering preserved across pointer wrap.
- Full boundary: count=4, in_valid=1, out_ready=1 -> pop occurs, push refused, count=3; next cycle push accepted, count=4.
- Flush: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_data=0; subsequent push of 41'hA appears one cycle later.
- Non-power-of-two: DEPTH=3, AF_LEVEL=2 -> pointers wrap 2->0, almost_full asserts at count=2, 10 sequential values read back in order.
